// File: rtl/acortex_dac_buf_pkg.sv
// Shared types and constants for the DAC PCM elastic buffer.
package acortex_dac_buf_pkg;

  localparam int unsigned PCM_W = 32;

  typedef enum logic [1:0] {
    DISABLED_S = 2'd0,
    PRIME_S    = 2'd1,
    STREAM_S   = 2'd2
  } buf_state_t;

  localparam logic [7:0] CTRL_ADDR     = 8'h00;
  localparam logic [7:0] THRESH_ADDR   = 8'h04;
  localparam logic [7:0] STATUS_ADDR   = 8'h08;
  localparam logic [7:0] UNDERRUN_ADDR = 8'h0C;

  localparam logic [31:0] DEFAULT_RD_DATA = 32'hdeadbabe;

  typedef struct packed {
    logic [PCM_W-1:0] lpcm;
    logic [PCM_W-1:0] rpcm;
  } pcm_pair_t;

endpackage

// File: rtl/acortex_sync_fifo.sv
// Single-clock FIFO with show-ahead head, synchronous flush and next-fill lookahead.
module acortex_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [$clog2(DEPTH):0]   fill_nxt_c,
  output logic                     full_c,
  output logic                     empty_c
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full_c  = (fill == FILL_W'(DEPTH));
  assign empty_c = (fill == '0);
  // Flush wins over any same-cycle push or pop
  assign push_ok = push & ~full_c & ~flush;
  assign pop_ok  = pop & ~empty_c & ~flush;
  assign head_c  = mem[rd_ptr];

  always_comb begin
    fill_nxt_c = fill;
    if (flush) fill_nxt_c = '0;
    else       fill_nxt_c = fill + FILL_W'(push_ok) - FILL_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      fill <= fill_nxt_c;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/acortex_dac_pcm_buf.sv
// Stereo PCM elastic buffer feeding the SSM2603 codec driver, with priming and underrun count.
// Optional macro ACORTEX_DAC_BUF_ZERO_FILL_EN: keep streaming silence on underrun.
module acortex_dac_pcm_buf
  import acortex_dac_buf_pkg::*;
#(
  parameter int unsigned LB_DATA_W = 32,
  parameter int unsigned LB_ADDR_W = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0] lb_addr,
  input  logic [LB_DATA_W-1:0] lb_wr_data,
  output logic                 lb_wr_valid,
  output logic                 lb_rd_valid,
  output logic [LB_DATA_W-1:0] lb_rd_data,
  input  logic                 pcm_in_valid,
  output logic                 pcm_in_ready,
  input  logic [31:0]          pcm_in_lpcm,
  input  logic [31:0]          pcm_in_rpcm,
  output logic                 dac_data_rdy,
  input  logic                 dac_pcm_nxt,
  output logic [31:0]          dac_lpcm_data,
  output logic [31:0]          dac_rpcm_data
);

  localparam int unsigned FILL_W = PTR_W + 1;

  buf_state_t        state, state_nxt;
  logic              en;
  logic [FILL_W-1:0] thresh;
  logic [15:0]       underrun_cnt;
  logic [FILL_W-1:0] fill, fill_nxt_c, thresh_eff_c;
  logic              full_c, empty_c;
  pcm_pair_t         wr_pair_c, head_c;
  logic              ctrl_wr_c, en_nxt_c, flush_c, push_c, pop_c, drain_c;
  logic              rdy_d_c, underrun_inc_c;
  logic [LB_DATA_W-1:0] rd_mux_c;
  logic              unused_c;

  assign ctrl_wr_c    = lb_wr_en & (lb_addr == LB_ADDR_W'(CTRL_ADDR));
  assign en_nxt_c     = ctrl_wr_c ? lb_wr_data[0] : en;
  // Writing flush, or clearing en, empties the buffer
  assign flush_c      = ctrl_wr_c & (lb_wr_data[1] | ~lb_wr_data[0]);
  assign push_c       = pcm_in_valid & pcm_in_ready;
  assign pop_c        = dac_pcm_nxt & dac_data_rdy & ~empty_c & ~flush_c;
  assign drain_c      = pop_c & ~push_c & (fill == FILL_W'(1));
  assign thresh_eff_c = (thresh == '0) ? FILL_W'(1) : thresh;
  assign wr_pair_c    = '{lpcm: pcm_in_lpcm, rpcm: pcm_in_rpcm};
  assign unused_c     = ^{lb_wr_data[LB_DATA_W-1:FILL_W], full_c};

  acortex_sync_fifo #(
    .WIDTH ($bits(pcm_pair_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_c),
    .pop        (pop_c),
    .flush      (flush_c),
    .wr_data    (wr_pair_c),
    .head_c     (head_c),
    .fill       (fill),
    .fill_nxt_c (fill_nxt_c),
    .full_c     (full_c),
    .empty_c    (empty_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= DISABLED_S;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!en_nxt_c)    state_nxt = DISABLED_S;
    else if (flush_c) state_nxt = PRIME_S;
    else begin
      case (state)
        DISABLED_S: state_nxt = PRIME_S;
        PRIME_S:    if (fill >= thresh_eff_c) state_nxt = STREAM_S;
        STREAM_S: begin
`ifndef ACORTEX_DAC_BUF_ZERO_FILL_EN
          if (drain_c) state_nxt = PRIME_S;
`endif
        end
        default:    state_nxt = DISABLED_S;
      endcase
    end
  end

  // A real pop leaves the output registers stale for one cycle, so ready drops for it
  always_comb begin
    rdy_d_c        = 1'b0;
    underrun_inc_c = 1'b0;
`ifdef ACORTEX_DAC_BUF_ZERO_FILL_EN
    rdy_d_c        = (state_nxt == STREAM_S) & ~pop_c & ~(empty_c & push_c);
    underrun_inc_c = dac_pcm_nxt & dac_data_rdy & empty_c & ~flush_c & (state == STREAM_S);
`else
    rdy_d_c        = (state_nxt == STREAM_S) & ~empty_c & ~pop_c;
    underrun_inc_c = (state == STREAM_S) & drain_c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_data_rdy  <= 1'b0;
      dac_lpcm_data <= '0;
      dac_rpcm_data <= '0;
      pcm_in_ready  <= 1'b0;
    end else begin
      dac_data_rdy <= rdy_d_c;
      pcm_in_ready <= (state_nxt != DISABLED_S) & (fill_nxt_c != FILL_W'(DEPTH));
      if (!empty_c) begin
        dac_lpcm_data <= head_c.lpcm;
        dac_rpcm_data <= head_c.rpcm;
      end
`ifdef ACORTEX_DAC_BUF_ZERO_FILL_EN
      else if (state_nxt == STREAM_S) begin
        dac_lpcm_data <= '0;
        dac_rpcm_data <= '0;
      end
`endif
    end
  end

  // Local bus registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      thresh       <= '0;
      underrun_cnt <= '0;
    end else begin
      en <= en_nxt_c;
      if (lb_wr_en && lb_addr == LB_ADDR_W'(THRESH_ADDR)) thresh <= lb_wr_data[FILL_W-1:0];
      if (lb_wr_en && lb_addr == LB_ADDR_W'(UNDERRUN_ADDR)) underrun_cnt <= '0;
      else if (underrun_inc_c && underrun_cnt != '1) underrun_cnt <= underrun_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_mux_c = LB_DATA_W'(DEFAULT_RD_DATA);
    case (lb_addr)
      LB_ADDR_W'(CTRL_ADDR):     rd_mux_c = LB_DATA_W'(en);
      LB_ADDR_W'(THRESH_ADDR):   rd_mux_c = LB_DATA_W'(thresh);
      LB_ADDR_W'(STATUS_ADDR):   rd_mux_c = LB_DATA_W'({state, fill});
      LB_ADDR_W'(UNDERRUN_ADDR): rd_mux_c = LB_DATA_W'(underrun_cnt);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_wr_valid <= 1'b0;
      lb_rd_valid <= 1'b0;
      lb_rd_data  <= '0;
    end else begin
      lb_wr_valid <= lb_wr_en;
      lb_rd_valid <= lb_rd_en;
      if (lb_rd_en) lb_rd_data <= rd_mux_c;
    end
  end

endmodule
